// File: rtl/relin_key_tile_mac.sv
// relin_key_tile_mac: three-stage modular multiply-accumulate over one key tile.
// Each lane j computes sum_i digits[i][j] * relin_key[i][j] mod MODULUS.
// Pipeline stages are P (exact products), R (per-product reduction) and
// S (lane sum and final reduction). The result appears three cycles after
// the tile is presented, one tile per cycle, with no backpressure.
// A sequence checker watches tile addresses and raises a sticky error on
// any out-of-order tile.
//
// Handshake: a tile is taken on every rising edge where in_valid=1 (there is
// no ready). out_valid is high for exactly the cycle that carries the result.
// out_address, out_c_sel, out_tile and row_done are meaningful only while
// out_valid=1. row_done is never high while out_valid is low.
module relin_key_tile_mac #(
  parameter int RELIN_KEY_TILE_WIDTH = 8,
  parameter int RELIN_KEY_LENGTH = 512,
  parameter int NUM_RELIN_KEYS = 8,
  parameter int DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] MODULUS = 64'h1FFF_FFFF_FFFF_FFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic [$clog2(RELIN_KEY_LENGTH):0] in_address,
  input  logic in_c_sel,
  input  logic [NUM_RELIN_KEYS-1:0][RELIN_KEY_TILE_WIDTH-1:0][DATA_WIDTH-1:0] relin_key,
  input  logic [NUM_RELIN_KEYS-1:0][RELIN_KEY_TILE_WIDTH-1:0][DATA_WIDTH-1:0] digits,
  output logic out_valid,
  output logic [$clog2(RELIN_KEY_LENGTH):0] out_address,
  output logic out_c_sel,
  output logic [RELIN_KEY_TILE_WIDTH-1:0][DATA_WIDTH-1:0] out_tile,
  output logic row_done,
  output logic seq_error
);

  localparam int AW = $clog2(RELIN_KEY_LENGTH) + 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = DATA_WIDTH + $clog2(NUM_RELIN_KEYS);
  localparam int NK = NUM_RELIN_KEYS;
  localparam int TW = RELIN_KEY_TILE_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RELIN_KEY_LENGTH - RELIN_KEY_TILE_WIDTH);
  localparam logic [AW-1:0] TILE_STEP = AW'(RELIN_KEY_TILE_WIDTH);
  localparam logic [PW-1:0] MOD_P = PW'(MODULUS);
  localparam logic [SW-1:0] MOD_S = SW'(MODULUS);

  // Stage P registers
  logic                                p_valid;
  logic [AW-1:0]                       p_addr;
  logic                                p_c_sel;
  logic [NK-1:0][TW-1:0][PW-1:0]       p_prod;
  logic [NK-1:0][TW-1:0][PW-1:0]       prod_d;

  // Stage R registers
  logic                                r_valid;
  logic [AW-1:0]                       r_addr;
  logic                                r_c_sel;
  logic [NK-1:0][TW-1:0][DATA_WIDTH-1:0] r_term;
  logic [NK-1:0][TW-1:0][DATA_WIDTH-1:0] term_d;

  // Stage S combinational lane sums
  logic [TW-1:0][SW-1:0]               sum_d;
  logic [TW-1:0][DATA_WIDTH-1:0]       lane_d;

  // Sequence checker state
  logic [AW-1:0]                       expected_addr;

  // Exact double-width products of every key/digit pair.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < NK; i++) begin
      for (int j = 0; j < TW; j++) begin
        prod_d[i][j] = PW'(relin_key[i][j]) * PW'(digits[i][j]);
      end
    end
  end

  // Reduce each product into the modulus range.
  always_comb begin
    term_d = '0;
    for (int i = 0; i < NK; i++) begin
      for (int j = 0; j < TW; j++) begin
        term_d[i][j] = DATA_WIDTH'(p_prod[i][j] % MOD_P);
      end
    end
  end

  // Per-lane sum of reduced terms; the extra bits hold the carries, so the
  // sum is exact before the final reduction.
  always_comb begin
    sum_d  = '0;
    lane_d = '0;
    for (int j = 0; j < TW; j++) begin
      for (int i = 0; i < NK; i++) begin
        sum_d[j] = sum_d[j] + SW'(r_term[i][j]);
      end
      lane_d[j] = DATA_WIDTH'(sum_d[j] % MOD_S);
    end
  end

  // Stage P: capture products and tags; data only moves for real tiles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_valid <= 1'b0;
      p_addr  <= '0;
      p_c_sel <= 1'b0;
      p_prod  <= '0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        p_addr  <= in_address;
        p_c_sel <= in_c_sel;
        p_prod  <= prod_d;
      end
    end
  end

  // Stage R: capture reduced terms and forward tags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_c_sel <= 1'b0;
      r_term  <= '0;
    end else begin
      r_valid <= p_valid;
      if (p_valid) begin
        r_addr  <= p_addr;
        r_c_sel <= p_c_sel;
        r_term  <= term_d;
      end
    end
  end

  // Stage S: register the reduced lane sums, tags and the end-of-row pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_address <= '0;
      out_c_sel   <= 1'b0;
      out_tile    <= '0;
      row_done    <= 1'b0;
    end else begin
      out_valid <= r_valid;
      row_done  <= r_valid && (r_addr == LAST_ADDR);
      if (r_valid) begin
        out_address <= r_addr;
        out_c_sel   <= r_c_sel;
        out_tile    <= lane_d;
      end
    end
  end

  // Sequence checker: flag an unexpected address, then resync to it. The last
  // tile of a row wraps the expectation back to 0 regardless of c_sel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      expected_addr <= '0;
      seq_error     <= 1'b0;
    end else if (in_valid) begin
      if (in_address != expected_addr) begin
        seq_error <= 1'b1;
      end
      expected_addr <= (in_address >= LAST_ADDR) ? '0 : (in_address + TILE_STEP);
    end
  end

endmodule

// File: tb/tb_relin_key_tile_mac.sv
// Testbench for relin_key_tile_mac: directed tiles with hand-derived lane
// values, a full row burst with re-burst, a skipped address, mid-burst reset,
// and random tiles with bubbles checked against a plain modular model.
module tb_relin_key_tile_mac;

  localparam int T  = 8;
  localparam int N  = 8;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int EW = AW + 1 + T * DW;
  localparam logic [63:0] M = 64'h1FFF_FFFF_FFFF_FFFF;
  localparam logic [AW-1:0] LAST = AW'(504);

  typedef logic [T-1:0][DW-1:0] tile_t;
  typedef logic [N-1:0][T-1:0][DW-1:0] ktile_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [AW-1:0] in_address;
  logic in_c_sel;
  ktile_t relin_key;
  ktile_t digits;
  logic out_valid;
  logic [AW-1:0] out_address;
  logic out_c_sel;
  tile_t out_tile;
  logic row_done;
  logic seq_error;

  int n_checks = 0;
  int n_pass = 0;
  int row_cnt = 0;
  int out_cnt = 0;
  logic mon_en = 1'b0;
  logic [2:0] h = '0;
  tile_t cur_exp;
  logic [EW-1:0] exp_q[$];

  relin_key_tile_mac dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_address(in_address),
    .in_c_sel(in_c_sel),
    .relin_key(relin_key),
    .digits(digits),
    .out_valid(out_valid),
    .out_address(out_address),
    .out_c_sel(out_c_sel),
    .out_tile(out_tile),
    .row_done(row_done),
    .seq_error(seq_error)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic tile_t ref_tile(input ktile_t k, input ktile_t d);
    tile_t r;
    logic [127:0] acc;
    for (int j = 0; j < T; j++) begin
      acc = '0;
      for (int i = 0; i < N; i++)
        acc = (acc + ({64'b0, k[i][j]} * {64'b0, d[i][j]}) % {64'b0, M}) % {64'b0, M};
      r[j] = acc[63:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_res();
    logic [63:0] v;
    v = {$urandom, $urandom} & 64'h1FFF_FFFF_FFFF_FFFF;
    if (v == M) v = '0;
    return v;
  endfunction

  // driver tasks
  task automatic set_tile(input logic [AW-1:0] a, input logic c, input ktile_t k,
                          input ktile_t d, input tile_t e);
    in_valid = 1'b1; in_address = a; in_c_sel = c;
    relin_key = k; digits = d; cur_exp = e;
  endtask

  task automatic drive_tile(input logic [AW-1:0] a, input logic c, input ktile_t k,
                            input ktile_t d, input tile_t e);
    @(posedge clk); #1;
    set_tile(a, c, k, d, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // leaves reset asserted; caller releases it
  task automatic hold_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_row_done"}, 64'(row_done), 64'd0);
    check_eq({tag, "_seq_error"}, 64'(seq_error), 64'd0);
    check_eq({tag, "_out_address"}, 64'(out_address), 64'd0);
    check_eq({tag, "_out_c_sel"}, 64'(out_c_sel), 64'd0);
    for (int j = 0; j < T; j++) check_eq($sformatf("%s_tile%0d", tag, j), out_tile[j], 64'd0);
  endtask

  // reference pipeline: valid history and expected result queue
  always @(posedge clk) begin
    if (!reset) begin
      h <= '0;
      exp_q.delete();
    end else begin
      h <= {h[1:0], in_valid};
      if (in_valid) exp_q.push_back({in_address, in_c_sel, cur_exp});
    end
  end

  // scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [AW-1:0] e_addr;
    tile_t e_tile;
    if (mon_en) begin
      check_eq("out_valid", 64'(out_valid), 64'(h[2]));
      if (out_valid === 1'b1) begin
        out_cnt++;
        if (row_done === 1'b1) row_cnt++;
        check_eq("exp_q_avail", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          e_addr = e[EW-1 -: AW];
          e_tile = e[T*DW-1:0];
          check_eq("out_address", 64'(out_address), 64'(e_addr));
          check_eq("out_c_sel", 64'(out_c_sel), 64'(e[T*DW]));
          check_eq("row_done", 64'(row_done), 64'(e_addr == LAST));
          for (int j = 0; j < T; j++) check_eq($sformatf("out_tile%0d", j), out_tile[j], e_tile[j]);
        end
      end else begin
        check_eq("row_done_idle", 64'(row_done), 64'd0);
      end
    end
  end

  initial begin
    ktile_t k, d;
    tile_t e;
    logic [AW-1:0] nxt;
    reset = 1'b0; in_valid = 1'b0; in_address = '0; in_c_sel = 1'b0;
    relin_key = '0; digits = '0; cur_exp = '0;
    hold_reset(3);
    check_zero_outputs("reset");
    mon_en = 1'b1;
    reset = 1'b1;
    idle(2);

    // keys 1, digit j: lane j = 8*j
    for (int i = 0; i < N; i++) for (int j = 0; j < T; j++) begin
      k[i][j] = 64'd1; d[i][j] = 64'(j);
    end
    for (int j = 0; j < T; j++) e[j] = 64'(8 * j);
    drive_tile(10'd0, 1'b0, k, d, e);
    idle(5);
    check_eq("seq_after_t1", 64'(seq_error), 64'd0);

    // keys M-1, digit 2: 8*(M-2) mod M = M-16
    for (int i = 0; i < N; i++) for (int j = 0; j < T; j++) begin
      k[i][j] = M - 64'd1; d[i][j] = 64'd2;
    end
    for (int j = 0; j < T; j++) e[j] = M - 64'd16;
    drive_tile(10'd8, 1'b1, k, d, e);
    // key above the modulus: 2^64-1 = 7 mod M, eight terms give 56
    for (int i = 0; i < N; i++) for (int j = 0; j < T; j++) begin
      k[i][j] = 64'hFFFF_FFFF_FFFF_FFFF; d[i][j] = 64'd1;
    end
    for (int j = 0; j < T; j++) e[j] = 64'd56;
    drive_tile(10'd16, 1'b0, k, d, e);
    idle(5);
    check_eq("seq_after_t2", 64'(seq_error), 64'd0);

    // two tiles then reset: neither may emerge
    drive_tile(10'd24, 1'b0, k, d, e);
    drive_tile(10'd32, 1'b0, k, d, e);
    hold_reset(2);
    check_zero_outputs("midreset");

    // full row burst 0..504 then 0 again, released straight into a tile
    row_cnt = 0; out_cnt = 0;
    for (int i = 0; i < N; i++) for (int j = 0; j < T; j++) begin
      k[i][j] = 64'd1; d[i][j] = 64'(j);
    end
    for (int j = 0; j < T; j++) e[j] = 64'(8 * j);
    reset = 1'b1;
    set_tile(10'd0, 1'b0, k, d, e);
    for (int a = 8; a <= 512; a += 8) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < T; j++) d[i][j] = 64'((a % 512) + j);
      for (int j = 0; j < T; j++) e[j] = 64'(8 * ((a % 512) + j));
      drive_tile(AW'(a % 512), (a == 512), k, d, e);
    end
    idle(6);
    check_eq("burst_seq_error", 64'(seq_error), 64'd0);
    check_eq("burst_row_done_cnt", 64'(row_cnt), 64'd1);
    check_eq("burst_out_cnt", 64'(out_cnt), 64'd65);

    // skipped address 16: error after the edge that samples 24, then sticky
    hold_reset(1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) for (int j = 0; j < T; j++) begin
      k[i][j] = rand_res(); d[i][j] = rand_res();
    end
    set_tile(10'd0, 1'b0, k, d, ref_tile(k, d));
    drive_tile(10'd8, 1'b0, k, d, ref_tile(k, d));
    for (int i = 0; i < N; i++) for (int j = 0; j < T; j++) d[i][j] = rand_res();
    drive_tile(10'd24, 1'b0, k, d, ref_tile(k, d));
    check_eq("skip_seq_before", 64'(seq_error), 64'd0);
    drive_tile(10'd32, 1'b0, k, d, ref_tile(k, d));
    check_eq("skip_seq_after", 64'(seq_error), 64'd1);
    idle(5);
    check_eq("skip_seq_sticky", 64'(seq_error), 64'd1);

    // random tiles with random bubbles
    hold_reset(1);
    reset = 1'b1;
    in_valid = 1'b0;
    nxt = '0;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle(1);
      end else begin
        for (int i = 0; i < N; i++) for (int j = 0; j < T; j++) begin
          k[i][j] = rand_res(); d[i][j] = rand_res();
        end
        drive_tile(nxt, 1'($urandom_range(0, 1)), k, d, ref_tile(k, d));
        nxt = nxt + AW'(8);
      end
    end
    idle(6);
    check_eq("rand_seq_error", 64'(seq_error), 64'd0);
    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
